// File: rtl/vga_pattern_sched_if.sv
// Pixel-path bundle between the VGA timing/control side and the pattern scheduler.
// master drives timing and controls; slave returns the registered pixel and status.
interface vga_pattern_sched_if;
    logic       video_on;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;
    logic       next_req;
    logic       auto_en;
    logic [7:0] sw;
    logic [7:0] rgb;
    logic [1:0] pattern;
    logic       pending;

    modport master (
        output video_on, x, y, frame_start, next_req, auto_en, sw,
        input  rgb, pattern, pending
    );

    modport slave (
        input  video_on, x, y, frame_start, next_req, auto_en, sw,
        output rgb, pattern, pending
    );
endinterface

// File: rtl/vga_pattern_sched.sv
// Frame-synchronous test-pattern scheduler and RGB332 pixel generator.
// Pixel latency 1 cycle; pattern/colour changes land only at frame_start; no backpressure.
module vga_pattern_sched #(
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int BAR_W              = 80
) (
    input  logic               clk,
    input  logic               rst_n,
    vga_pattern_sched_if.slave bus
);
    typedef enum logic [1:0] {
        PAT_SOLID    = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_CHECKER  = 2'd2,
        PAT_GRADIENT = 2'd3
    } pat_e;

    localparam logic [9:0] FRAME_LAST = 10'(FRAMES_PER_PATTERN - 1);
    localparam logic [9:0] BAR_LAST   = 10'(BAR_W - 1);

    pat_e       pat_q, pat_d;
    logic       pend_q, pend_d;
    logic [9:0] fcnt_q, fcnt_d;
    logic [7:0] swq_q, swq_d;
    logic       req_q;
    logic [9:0] col_q, col_d;
    logic [2:0] bar_q, bar_d;
    logic [7:0] rgb_q, rgb_d;
    logic       req_edge, auto_adv, manual_adv;
    logic       unused_bits;

    // Only the cell/gradient bits of x and y feed the pixel function.
    assign unused_bits = ^{bus.x[4:0], bus.y[9], bus.y[4:0]};

    always_comb begin
        req_edge   = bus.next_req & ~req_q;
        auto_adv   = bus.auto_en && (fcnt_q == FRAME_LAST);
        manual_adv = pend_q | req_edge;
        pat_d      = pat_q;
        pend_d     = pend_q;
        fcnt_d     = fcnt_q;
        swq_d      = swq_q;

        if (bus.frame_start) begin
            swq_d  = bus.sw;
            pend_d = 1'b0;
            if (manual_adv || auto_adv) begin
                pat_d = pat_e'(pat_q + 2'd1);
            end
            // A manual advance restarts the auto interval, same as a wrap.
            if (!bus.auto_en || manual_adv || auto_adv) begin
                fcnt_d = 10'd0;
            end else begin
                fcnt_d = fcnt_q + 10'd1;
            end
        end else if (req_edge) begin
            pend_d = 1'b1;
        end
    end

    always_comb begin
        col_d = 10'd0;
        bar_d = 3'd0;
        rgb_d = 8'h00;
        if (bus.video_on) begin
            // Counters track x/BAR_W assuming x runs 0,1,2.. from the start of each line.
            if (col_q == BAR_LAST) begin
                col_d = 10'd0;
                bar_d = bar_q + 3'd1;
            end else begin
                col_d = col_q + 10'd1;
                bar_d = bar_q;
            end
            case (pat_q)
                PAT_SOLID:    rgb_d = swq_q;
                PAT_BARS:     rgb_d = {{3{bar_q[2]}}, {3{bar_q[1]}}, {2{bar_q[0]}}};
                PAT_CHECKER:  rgb_d = (bus.x[5] ^ bus.y[5]) ? ~swq_q : swq_q;
                PAT_GRADIENT: rgb_d = {bus.x[9:7], bus.y[8:6], bus.x[6:5]};
                default:      rgb_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pat_q  <= PAT_SOLID;
            pend_q <= 1'b0;
            fcnt_q <= 10'd0;
            swq_q  <= 8'h00;
            req_q  <= 1'b0;
            col_q  <= 10'd0;
            bar_q  <= 3'd0;
            rgb_q  <= 8'h00;
        end else begin
            pat_q  <= pat_d;
            pend_q <= pend_d;
            fcnt_q <= fcnt_d;
            swq_q  <= swq_d;
            req_q  <= bus.next_req;
            col_q  <= col_d;
            bar_q  <= bar_d;
            rgb_q  <= rgb_d;
        end
    end

    assign bus.rgb     = rgb_q;
    assign bus.pattern = pat_q;
    assign bus.pending = pend_q;
endmodule

// File: tb/tb_vga_pattern_sched.sv
// Directed bench for vga_pattern_sched: per-cycle comparison against a rule-level model,
// plus hand-computed literal expectations at key points of the stimulus.
module tb_vga_pattern_sched;
    localparam int FPP = 3;
    localparam int BW  = 80;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_pattern_sched_if bus ();

    vga_pattern_sched #(.FRAMES_PER_PATTERN(FPP), .BAR_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pixel rule written straight from the pattern definitions (true division for bars).
    function automatic logic [7:0] pix(input logic [1:0] p, input logic [7:0] s,
                                       input int xx, input int yy);
        logic [2:0] i;
        logic [9:0] xv;
        logic [9:0] yv;
        xv = 10'(xx);
        yv = 10'(yy);
        i  = 3'((xx / BW) % 8);
        case (p)
            2'd0:    return s;
            2'd1:    return {{3{i[2]}}, {3{i[1]}}, {2{i[0]}}};
            2'd2:    return (xv[5] ^ yv[5]) ? ~s : s;
            default: return {xv[9:7], yv[8:6], xv[6:5]};
        endcase
    endfunction

    logic [7:0] m_rgb, m_swq;
    logic [1:0] m_pat;
    logic       m_pend, m_prev;
    int         m_frames;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin : model
        bit req, man, aut;
        if (!rst_n) begin
            m_rgb    <= 8'h00;
            m_pat    <= 2'd0;
            m_pend   <= 1'b0;
            m_frames <= 0;
            m_swq    <= 8'h00;
            m_prev   <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            req = bus.next_req && !m_prev;
            m_rgb  <= bus.video_on ? pix(m_pat, m_swq, int'(bus.x), int'(bus.y)) : 8'h00;
            m_prev <= bus.next_req;
            if (bus.frame_start) begin
                man = m_pend || req;
                aut = bus.auto_en && (m_frames == FPP - 1);
                if (man || aut) m_pat <= 2'((m_pat + 1) % 4);
                m_frames <= (!bus.auto_en || man || aut) ? 0 : m_frames + 1;
                m_swq    <= bus.sw;
                m_pend   <= 1'b0;
            end else if (req) begin
                m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_rgb", 32'(bus.rgb), 32'(m_rgb));
            chk("model_pattern", 32'(bus.pattern), 32'(m_pat));
            chk("model_pending", 32'(bus.pending), 32'(m_pend));
        end
    end

    logic [7:0] line_rgb [0:639];
    logic [7:0] bar_tab [0:7];

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_req(input int hold);
        @(negedge clk);
        bus.next_req = 1'b1;
        repeat (hold) @(negedge clk);
        bus.next_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic drive_line(input int yy, input int n);
        for (int xx = 0; xx < n; xx++) begin
            @(negedge clk);
            if (xx > 0) line_rgb[xx-1] = bus.rgb;
            bus.video_on = 1'b1;
            bus.x        = 10'(xx);
            bus.y        = 10'(yy);
        end
        @(negedge clk);
        line_rgb[n-1] = bus.rgb;
        bus.video_on  = 1'b0;
        bus.x         = 10'd0;
        bus.y         = 10'd0;
    endtask

    initial begin
        bar_tab[0] = 8'h00; bar_tab[1] = 8'h03; bar_tab[2] = 8'h1C; bar_tab[3] = 8'h1F;
        bar_tab[4] = 8'hE0; bar_tab[5] = 8'hE3; bar_tab[6] = 8'hFC; bar_tab[7] = 8'hFF;
        bus.video_on    = 1'b0;
        bus.x           = 10'd0;
        bus.y           = 10'd0;
        bus.frame_start = 1'b0;
        bus.next_req    = 1'b0;
        bus.auto_en     = 1'b0;
        bus.sw          = 8'hE3;

        idle(3);
        chk("reset_rgb", 32'(bus.rgb), 32'h00);
        chk("reset_pattern", 32'(bus.pattern), 32'd0);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // SOLID with latched switch colour, then blanking
        frame();
        drive_line(0, 8);
        chk("solid_rgb", 32'(line_rgb[3]), 32'hE3);
        idle(1);
        chk("blank_rgb", 32'(bus.rgb), 32'h00);

        // Manual advance, held button counts once
        pulse_req(3);
        chk("req_pending", 32'(bus.pending), 32'd1);
        chk("req_pattern_hold", 32'(bus.pattern), 32'd0);
        frame();
        chk("adv_pattern", 32'(bus.pattern), 32'd1);
        chk("adv_pending", 32'(bus.pending), 32'd0);

        // BARS sweep: first and last pixel of each bar
        drive_line(0, 640);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("bar%0d_first", k), 32'(line_rgb[k*BW]), 32'(bar_tab[k]));
            chk($sformatf("bar%0d_last", k), 32'(line_rgb[k*BW+BW-1]), 32'(bar_tab[k]));
        end

        // Three requests in one frame advance once
        pulse_req(1);
        pulse_req(1);
        pulse_req(1);
        frame();
        chk("multi_req_pattern", 32'(bus.pattern), 32'd2);

        // CHECKER, colour change mid-frame held until frame_start
        bus.sw = 8'h5A;
        drive_line(0, 40);
        chk("chk_old_colour", 32'(line_rgb[0]), 32'hE3);
        chk("chk_x32_inv", 32'(line_rgb[32]), 32'h1C);
        frame();
        drive_line(0, 40);
        chk("chk_new_colour", 32'(line_rgb[0]), 32'h5A);
        drive_line(32, 40);
        chk("chk_y32_inv", 32'(line_rgb[0]), 32'hA5);

        // GRADIENT
        pulse_req(1);
        frame();
        chk("grad_pattern", 32'(bus.pattern), 32'd3);
        drive_line(100, 200);
        chk("grad_130_100", 32'(line_rgb[130]), 32'h24);

        // Auto mode with FPP=3
        bus.auto_en = 1'b1;
        for (int f = 1; f <= 12; f++) begin
            frame();
            idle(2);
            if (f == 2)  chk("auto_f2", 32'(bus.pattern), 32'd3);
            if (f == 3)  chk("auto_f3", 32'(bus.pattern), 32'd0);
            if (f == 6)  chk("auto_f6", 32'(bus.pattern), 32'd1);
            if (f == 9)  chk("auto_f9", 32'(bus.pattern), 32'd2);
            if (f == 12) chk("auto_f12", 32'(bus.pattern), 32'd3);
        end

        // Request edge coincides with the auto-wrap frame_start
        frame();
        frame();
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.next_req    = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        @(negedge clk);
        chk("coinc_pattern", 32'(bus.pattern), 32'd0);
        chk("coinc_pending", 32'(bus.pending), 32'd0);
        bus.next_req = 1'b0;
        frame();
        frame();
        chk("coinc_cnt_f2", 32'(bus.pattern), 32'd0);
        frame();
        chk("coinc_cnt_f3", 32'(bus.pattern), 32'd1);

        // Auto disabled, mid-frame toggle ignored
        bus.auto_en = 1'b0;
        for (int f = 0; f < 10; f++) begin
            frame();
            if (f == 4) begin
                bus.auto_en = 1'b1;
                idle(2);
                bus.auto_en = 1'b0;
            end
        end
        chk("auto_off_pattern", 32'(bus.pattern), 32'd1);

        // Reset mid-frame
        pulse_req(1);
        chk("pre_rst_pending", 32'(bus.pending), 32'd1);
        @(negedge clk);
        bus.video_on = 1'b1;
        bus.x        = 10'd0;
        bus.sw       = 8'h3C;
        rst_n        = 1'b0;
        @(negedge clk);
        chk("midrst_rgb", 32'(bus.rgb), 32'h00);
        chk("midrst_pattern", 32'(bus.pattern), 32'd0);
        chk("midrst_pending", 32'(bus.pending), 32'd0);
        rst_n        = 1'b1;
        bus.video_on = 1'b0;
        idle(1);
        frame();
        drive_line(5, 4);
        chk("post_rst_solid", 32'(line_rgb[2]), 32'h3C);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
